// File: rtl/brq_iccm_pkg.sv
// -----------------------------------------------------------------------------
// brq_iccm_pkg
// Shared definitions for the ICCM loader/fetch arbiter:
//   - DefDataWidth / DefAddrWidth : default ICCM word width and word-address width
//   - state_e                     : arbiter mode (LOAD / RUN / DRAIN)
// -----------------------------------------------------------------------------
package brq_iccm_pkg;

   localparam int unsigned DefDataWidth = 32;
   localparam int unsigned DefAddrWidth = 15;

   // LOAD is the reset state: the core is held in reset while the loader
   // fills the ICCM. RUN hands the ICCM to instruction fetch. DRAIN is a
   // single cycle that lets an in-flight fetch response retire before the
   // loader takes the memory back.
   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage : brq_iccm_pkg

// File: rtl/iccm_arbiter_if.sv
// -----------------------------------------------------------------------------
// iccm_arbiter_if
// Bundles the three buses that meet at the ICCM arbiter.
//   Loader : ld_valid, ld_ready, ld_addr, ld_data, ld_done, boot_req
//   Fetch  : if_req, if_addr, if_gnt, if_rvalid, if_rdata
//   ICCM   : mem_addr, mem_write, mem_read, mem_wdata, mem_rdata
// Modports:
//   slave  : the arbiter's view (drives ld_ready, if_*, mem_* outputs)
//   master : the environment's view (loader, fetch unit and ICCM macro)
// -----------------------------------------------------------------------------
interface iccm_arbiter_if
   import brq_iccm_pkg::*;
#(
   parameter int unsigned DataWidth = DefDataWidth,
   parameter int unsigned AddrWidth = DefAddrWidth
);

   // Loader side
   logic                 ld_valid;
   logic                 ld_ready;
   logic [AddrWidth-1:0] ld_addr;
   logic [DataWidth-1:0] ld_data;
   logic                 ld_done;
   logic                 boot_req;

   // Instruction-fetch side
   logic                 if_req;
   logic [AddrWidth-1:0] if_addr;
   logic                 if_gnt;
   logic                 if_rvalid;
   logic [DataWidth-1:0] if_rdata;

   // ICCM side (read data is combinational from mem_addr)
   logic [AddrWidth-1:0] mem_addr;
   logic                 mem_write;
   logic                 mem_read;
   logic [DataWidth-1:0] mem_wdata;
   logic [DataWidth-1:0] mem_rdata;

   modport slave (
      input  ld_valid, ld_addr, ld_data, ld_done, boot_req,
      input  if_req, if_addr,
      input  mem_rdata,
      output ld_ready,
      output if_gnt, if_rvalid, if_rdata,
      output mem_addr, mem_write, mem_read, mem_wdata
   );

   modport master (
      output ld_valid, ld_addr, ld_data, ld_done, boot_req,
      output if_req, if_addr,
      output mem_rdata,
      input  ld_ready,
      input  if_gnt, if_rvalid, if_rdata,
      input  mem_addr, mem_write, mem_read, mem_wdata
   );

endinterface : iccm_arbiter_if

// File: rtl/iccm_arbiter.sv
// -----------------------------------------------------------------------------
// iccm_arbiter
// Shares one single-port ICCM between a program loader and instruction fetch.
// While loading, the core is held in reset and loader writes pass straight
// through to the ICCM. After ld_done the core is released and fetch reads
// are granted one per cycle with a one-cycle response. boot_req returns the
// block to load mode via a one-cycle DRAIN.
//
// Ports:
//   brq_clk     in   sole clock, rising edge
//   brq_rst_n   in   asynchronous active-low reset
//   bus         if   loader / fetch / ICCM signals (iccm_arbiter_if.slave)
//   core_rst_n  out  core reset, active low (low in LOAD and DRAIN)
//   load_count  out  words written this load session, saturating at 2**AddrWidth
// -----------------------------------------------------------------------------
module iccm_arbiter
   import brq_iccm_pkg::*;
#(
   parameter int unsigned DataWidth = DefDataWidth,
   parameter int unsigned AddrWidth = DefAddrWidth
) (
   input  logic               brq_clk,
   input  logic               brq_rst_n,
   iccm_arbiter_if.slave      bus,
   output logic               core_rst_n,
   output logic [AddrWidth:0] load_count
);

   localparam logic [AddrWidth:0] CountMax = {1'b1, {AddrWidth{1'b0}}};
   localparam logic [AddrWidth:0] CountOne = (AddrWidth+1)'(1);

   state_e               state_q, state_d;
   logic [AddrWidth:0]   count_q, count_d;
   logic                 rvalid_q;
   logic [DataWidth-1:0] rdata_q;
   logic                 core_rst_n_q;
   logic                 wr_commit;

   // Mode decode: next state plus every arbiter-driven bus signal.
   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned; that is what keeps this block free of latches.
   always_comb begin
      state_d       = state_q;
      bus.ld_ready  = 1'b0;
      bus.if_gnt    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_write = 1'b0;
      bus.mem_read  = 1'b0;

      case (state_q)
         LOAD: begin
            bus.ld_ready  = 1'b1;
            bus.mem_addr  = bus.ld_addr;
            bus.mem_wdata = bus.ld_data;
            bus.mem_write = bus.ld_valid;
            // A write presented with ld_done still commits on this edge.
            if (bus.ld_done) state_d = RUN;
         end
         RUN: begin
            bus.mem_addr = bus.if_addr;
            bus.mem_read = bus.if_req;
            // boot_req wins over a fetch in the same cycle.
            bus.if_gnt   = bus.if_req && !bus.boot_req;
            if (bus.boot_req) state_d = DRAIN;
         end
         DRAIN: begin
            state_d = LOAD;
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   assign wr_commit = bus.ld_valid && bus.ld_ready;

   always_comb begin
      count_d = count_q;
      if (state_q == DRAIN) begin
         // Leaving DRAIN always lands in LOAD: start a fresh session count.
         count_d = '0;
      end else if (wr_commit && (count_q != CountMax)) begin
         count_d = count_q + CountOne;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge value of every other, independent of process order.
   always_ff @(posedge brq_clk or negedge brq_rst_n) begin
      if (!brq_rst_n) begin
         state_q      <= LOAD;
         count_q      <= '0;
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
         core_rst_n_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         rvalid_q     <= bus.if_gnt;
         // Hold the last fetched word when no new fetch is granted.
         if (bus.if_gnt) rdata_q <= bus.mem_rdata;
         // Registered from the next state so core_rst_n is glitch-free and
         // rises on the same edge that enters RUN.
         core_rst_n_q <= (state_d == RUN);
      end
   end

   assign bus.if_rvalid = rvalid_q;
   assign bus.if_rdata  = rdata_q;
   assign core_rst_n    = core_rst_n_q;
   assign load_count    = count_q;

endmodule : iccm_arbiter

// File: tb/tb_iccm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_iccm_arbiter
// Self-checking bench for iccm_arbiter. The bench owns the ICCM array and a
// reference copy of what it expects the ICCM to hold; fetch expectations are
// queued with the cycle their response is due and retired by a monitor.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_iccm_arbiter;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 15;
   localparam int unsigned DEPTH = 1 << AW;
   localparam logic [AW:0] CMAX  = {1'b1, {AW{1'b0}}};

   logic          brq_clk;
   logic          brq_rst_n;
   logic          core_rst_n;
   logic [AW:0]   load_count;

   iccm_arbiter_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

   iccm_arbiter #(.DataWidth(DW), .AddrWidth(AW)) dut (
      .brq_clk    (brq_clk),
      .brq_rst_n  (brq_rst_n),
      .bus        (bus),
      .core_rst_n (core_rst_n),
      .load_count (load_count)
   );

   // ICCM model: synchronous write, combinational read.
   logic [DW-1:0] iccm    [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];

   assign bus.mem_rdata = iccm[bus.mem_addr];

   always @(posedge brq_clk) begin
      if (bus.mem_write) iccm[bus.mem_addr] <= bus.mem_wdata;
   end

   initial begin
      brq_clk = 1'b0;
      forever #5 brq_clk = ~brq_clk;
   end

   int cyc = 0;
   always @(posedge brq_clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard of outstanding fetch responses.
   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t        sb[$];
   logic [AW:0] exp_count;

   always @(negedge brq_clk) begin
      if (brq_rst_n) begin
         while (sb.size() != 0 && sb[0].due < cyc) begin
            check("rvalid_missed_due", 64'(sb[0].due), 64'(cyc));
            void'(sb.pop_front());
         end
         if (sb.size() != 0 && sb[0].due == cyc) begin
            check("if_rvalid", bus.if_rvalid, 1'b1);
            check("if_rdata", bus.if_rdata, sb[0].data);
            void'(sb.pop_front());
         end else begin
            check("if_rvalid_idle", bus.if_rvalid, 1'b0);
         end
         check("rw_exclusive", bus.mem_write & bus.mem_read, 1'b0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      @(posedge brq_clk); #1;
      bus.ld_valid = 1'b0;
      bus.ld_done  = 1'b0;
      bus.boot_req = 1'b0;
      bus.if_req   = 1'b0;
   endtask

   task automatic ld_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic done);
      @(posedge brq_clk); #1;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = a;
      bus.ld_data  = d;
      bus.ld_done  = done;
      bus.if_req   = 1'b0;
      #1;
      check("ld_ready_load", bus.ld_ready, 1'b1);
      check("mem_write_load", bus.mem_write, 1'b1);
      check("mem_addr_load", bus.mem_addr, a);
      check("mem_wdata_load", bus.mem_wdata, d);
      check("core_rst_n_load", core_rst_n, 1'b0);
      ref_mem[a] = d;
      if (exp_count != CMAX) exp_count = exp_count + 1'b1;
   endtask

   task automatic fetch(input logic [AW-1:0] a);
      @(posedge brq_clk); #1;
      bus.ld_valid = 1'b0;
      bus.ld_done  = 1'b0;
      bus.boot_req = 1'b0;
      bus.if_req   = 1'b1;
      bus.if_addr  = a;
      #1;
      check("if_gnt", bus.if_gnt, 1'b1);
      check("mem_read", bus.mem_read, 1'b1);
      check("mem_addr_fetch", bus.mem_addr, a);
      sb.push_back('{data: ref_mem[a], due: cyc + 1});
   endtask

   initial begin
      brq_rst_n    = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_addr  = '0;
      bus.ld_data  = '0;
      bus.ld_done  = 1'b0;
      bus.boot_req = 1'b0;
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      exp_count    = '0;

      // Reset state.
      #3;
      check("rst_core_rst_n", core_rst_n, 1'b0);
      check("rst_load_count", load_count, '0);
      check("rst_if_rvalid", bus.if_rvalid, 1'b0);
      check("rst_if_rdata", bus.if_rdata, '0);
      check("rst_ld_ready", bus.ld_ready, 1'b1);
      @(negedge brq_clk);
      @(negedge brq_clk);
      brq_rst_n = 1'b1;

      // Load four words, then ld_done.
      for (int i = 0; i < 4; i++) ld_write(AW'(i), 32'hA0 + 32'(i), 1'b0);
      @(posedge brq_clk); #1;
      bus.ld_valid = 1'b0;
      bus.ld_done  = 1'b1;
      #1;
      check("core_rst_n_at_done", core_rst_n, 1'b0);
      check("load_count_4", load_count, exp_count);
      @(posedge brq_clk); #1;
      bus.ld_done = 1'b0;
      #1;
      check("core_rst_n_run", core_rst_n, 1'b1);
      check("ld_ready_run", bus.ld_ready, 1'b0);
      check("load_count_run", load_count, 4);

      // Back-to-back fetches, then rdata must hold.
      fetch(0);
      fetch(1);
      fetch(2);
      idle();
      @(posedge brq_clk);
      @(posedge brq_clk); #1;
      check("rdata_hold", bus.if_rdata, 32'hA2);

      // Loader activity in RUN is ignored.
      @(posedge brq_clk); #1;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 1;
      bus.ld_data  = 32'h55;
      bus.ld_done  = 1'b1;
      #1;
      check("ld_ready_ignored", bus.ld_ready, 1'b0);
      check("mem_write_ignored", bus.mem_write, 1'b0);
      idle();
      #1;
      check("iccm_unchanged", iccm[1], ref_mem[1]);
      check("still_run", core_rst_n, 1'b1);
      check("load_count_unchanged", load_count, 4);

      // boot_req with a fetch: no grant, DRAIN, then LOAD.
      fetch(3);
      @(posedge brq_clk); #1;
      bus.boot_req = 1'b1;
      bus.if_req   = 1'b1;
      bus.if_addr  = 2;
      #1;
      check("boot_no_gnt", bus.if_gnt, 1'b0);
      check("boot_core_rst_n", core_rst_n, 1'b1);
      @(posedge brq_clk); #1;
      bus.boot_req = 1'b0;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 3;
      bus.ld_data  = 32'h77;
      #1;
      check("drain_core_rst_n", core_rst_n, 1'b0);
      check("drain_ld_ready", bus.ld_ready, 1'b0);
      check("drain_if_gnt", bus.if_gnt, 1'b0);
      check("drain_mem_read", bus.mem_read, 1'b0);
      check("drain_mem_write", bus.mem_write, 1'b0);
      @(posedge brq_clk); #1;
      bus.ld_valid = 1'b0;
      bus.if_req   = 1'b0;
      #1;
      check("reload_ld_ready", bus.ld_ready, 1'b1);
      check("reload_load_count", load_count, '0);
      check("reload_core_rst_n", core_rst_n, 1'b0);
      check("drain_write_dropped", iccm[3], ref_mem[3]);
      exp_count = '0;

      // ld_valid together with ld_done.
      ld_write(5, 32'hDEADBEEF, 1'b1);
      idle();
      #1;
      check("done_wr_core_rst_n", core_rst_n, 1'b1);
      check("done_wr_load_count", load_count, exp_count);
      check("done_wr_iccm", iccm[5], 32'hDEADBEEF);
      fetch(5);
      fetch(0);

      // Reset mid-fetch: the previous response is visible, this one granted.
      fetch(1);
      #4;
      brq_rst_n = 1'b0;
      sb.delete();
      bus.if_req = 1'b0;
      #1;
      check("midrst_if_rvalid", bus.if_rvalid, 1'b0);
      check("midrst_if_rdata", bus.if_rdata, '0);
      check("midrst_core_rst_n", core_rst_n, 1'b0);
      check("midrst_ld_ready", bus.ld_ready, 1'b1);
      check("midrst_load_count", load_count, '0);

      // A write held during reset is not counted.
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 9;
      bus.ld_data  = 32'h99;
      @(posedge brq_clk); #1;
      check("rst_write_not_counted", load_count, '0);
      bus.ld_valid = 1'b0;
      @(negedge brq_clk);
      brq_rst_n = 1'b1;
      exp_count = '0;

      // Fill past the top: load_count saturates at 2**AW.
      for (int i = 0; i < int'(DEPTH) + 2; i++) begin
         @(posedge brq_clk); #1;
         bus.ld_valid = 1'b1;
         bus.ld_addr  = AW'(i);
         bus.ld_data  = 32'(i) ^ 32'h5A5A_0000;
         ref_mem[AW'(i)] = 32'(i) ^ 32'h5A5A_0000;
         if (exp_count != CMAX) exp_count = exp_count + 1'b1;
      end
      @(posedge brq_clk); #1;
      bus.ld_valid = 1'b0;
      bus.ld_done  = 1'b1;
      #1;
      check("load_count_sat", load_count, exp_count);
      @(posedge brq_clk); #1;
      bus.ld_done = 1'b0;
      #1;
      check("sat_core_rst_n", core_rst_n, 1'b1);
      check("sat_load_count_hold", load_count, CMAX);
      fetch(AW'(DEPTH - 1));
      fetch(0);
      fetch(7);
      idle();
      repeat (3) @(posedge brq_clk);
      #1;
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_iccm_arbiter

// File: doc/iccm_arbiter.md
ICCM_ARBITER -- requirements
Module: iccm_arbiter

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32, meaning the ICCM word width.
REQ-002 The block SHALL have parameter AddrWidth, default 15, meaning the ICCM word-address width (depth 2**AddrWidth).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with the ports below.
- brq_clk  in  1  sole clock, rising edge.
- brq_rst_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  loader write request.
- ld_ready  out  1  loader write accepted.
- ld_addr  in  AddrWidth  loader word address.
- ld_data  in  DataWidth  loader write data.
- ld_done  in  1  loader end-of-program pulse.
- boot_req  in  1  request to re-enter load mode.
- if_req  in  1  fetch read request.
- if_addr  in  AddrWidth  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DataWidth  fetch read data.
- mem_addr  out  AddrWidth  ICCM address.
- mem_write  out  1  ICCM write enable.
- mem_read  out  1  ICCM read enable.
- mem_wdata  out  DataWidth  ICCM write data.
- mem_rdata  in  DataWidth  ICCM combinational read data.
- core_rst_n  out  1  core reset, active low.
- load_count  out  AddrWidth+1  words written in the current load session.

Function
REQ-004 The FSM SHALL have states LOAD, RUN and DRAIN; LOAD is the reset state.
REQ-005 In LOAD: ld_ready=1, if_gnt=0, core_rst_n=0, and mem_addr/mem_wdata/mem_write SHALL follow ld_addr/ld_data/ld_valid combinationally; mem_read=0.
REQ-006 A write SHALL commit on any edge with ld_valid&&ld_ready; load_count increments by 1 and saturates at 2**AddrWidth.
REQ-007 In LOAD, ld_done=1 SHALL move the FSM to RUN on the next edge; ld_valid in the same cycle SHALL still commit its write first.
REQ-008 Entering LOAD from DRAIN SHALL clear load_count to 0.
REQ-009 In RUN: ld_ready=0, mem_write=0, core_rst_n=1, mem_addr=if_addr, mem_read=if_req, if_gnt=if_req&&!boot_req.
REQ-010 A granted fetch SHALL register mem_rdata into if_rdata and SHALL pulse if_rvalid for exactly one cycle on the following cycle (latency 1, throughput 1 per cycle).
REQ-011 In RUN, boot_req=1 SHALL take priority over if_req: no grant that cycle, and the FSM moves to DRAIN.
REQ-012 In DRAIN: core_rst_n=0, if_gnt=0, ld_ready=0, no ICCM access; any in-flight if_rvalid completes; the FSM SHALL move to LOAD after exactly one cycle.
REQ-013 ld_done or ld_valid outside LOAD SHALL be ignored, and ld_ready SHALL stay 0.
REQ-014 if_rdata SHALL hold its last value when if_rvalid=0.
REQ-015 mem_write and mem_read SHALL never both be 1.

Reset
REQ-016 Reset assertion SHALL asynchronously force state=LOAD, if_rvalid=0, if_rdata=0, load_count=0 and core_rst_n=0, regardless of any transaction in flight.
REQ-017 A write coincident with reset assertion SHALL be considered not committed by this block.

Structure
REQ-018 The state enum (LOAD/RUN/DRAIN) and the default width constants SHALL live in a shared package, brq_iccm_pkg.
REQ-019 The block SHALL be a single module with no sub-modules; the ICCM itself stays external.

Verification
REQ-020 Reset, then load 4 words (addr 0..3, data 0xA0..0xA3), then pulse ld_done -> load_count=4, FSM in RUN, core_rst_n rises 1 cycle after ld_done.
REQ-021 In RUN, fetch on consecutive cycles from addr 0,1,2 -> if_rvalid high for 3 cycles starting 1 cycle later, with if_rdata=0xA0,0xA1,0xA2.
REQ-022 In LOAD, assert ld_valid and ld_done together (addr 5, data 0xDEADBEEF) -> write committed, load_count incremented, RUN next cycle.
REQ-023 In RUN, assert boot_req and if_req together -> if_gnt=0, DRAIN 1 cycle, LOAD with load_count=0 and core_rst_n=0.
REQ-024 In RUN, assert ld_valid -> ld_ready=0, mem_write=0, ICCM unchanged.
REQ-025 Assert brq_rst_n low mid-fetch (after grant, before if_rvalid) -> if_rvalid=0 immediately, state=LOAD, core_rst_n=0.
